// File: rtl/rom_read_arbiter.sv
// Round-robin read arbiter sharing one registered single-port ROM between NUM_REQ requesters.
// Define ROM_ARB_PERF_EN to add grant/stall performance counters.
module rom_read_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int ROM_LATENCY = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]           rsp_data,
  output logic [ADDR_W-1:0]           rom_address,
  input  logic [DATA_W-1:0]           rom_data
`ifdef ROM_ARB_PERF_EN
  ,
  output logic [15:0]                 stall_cnt,
  output logic [15:0]                 grant_cnt
`endif
);

  localparam int PW = $clog2(NUM_REQ);

  logic [PW-1:0]      ptr_q, ptr_d;
  logic [ADDR_W-1:0]  rom_address_q, rom_address_d;
  logic [NUM_REQ-1:0] grant;
  logic               grant_any;
  logic [PW-1:0]      scan_idx;

  // Stage 0 tracks the rom_address register; the remaining ROM_LATENCY stages track the ROM itself.
  logic [NUM_REQ-1:0] tag_q [ROM_LATENCY+1];
  logic [NUM_REQ-1:0] tag_d [ROM_LATENCY+1];

  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    scan_idx  = ptr_q;
    for (int off = 0; off < NUM_REQ; off++) begin
      scan_idx = (scan_idx == PW'(NUM_REQ - 1)) ? '0 : scan_idx + 1'b1;
      if (!grant_any && req_valid[scan_idx]) begin
        grant_any       = 1'b1;
        grant[scan_idx] = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d         = ptr_q;
    rom_address_d = rom_address_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        ptr_d         = PW'(i);
        rom_address_d = req_addr[i*ADDR_W +: ADDR_W];
      end
    end
    tag_d[0] = grant;
    for (int s = 1; s <= ROM_LATENCY; s++) begin
      tag_d[s] = tag_q[s-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q         <= PW'(NUM_REQ - 1);
      rom_address_q <= '0;
      for (int s = 0; s <= ROM_LATENCY; s++) begin
        tag_q[s] <= '0;
      end
    end else begin
      ptr_q         <= ptr_d;
      rom_address_q <= rom_address_d;
      for (int s = 0; s <= ROM_LATENCY; s++) begin
        tag_q[s] <= tag_d[s];
      end
    end
  end

  assign req_ready   = rst_n ? grant : '0;
  assign rom_address = rom_address_q;
  assign rsp_valid   = tag_q[ROM_LATENCY];
  assign rsp_data    = rom_data;

`ifdef ROM_ARB_PERF_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] grant_cnt_q, grant_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    grant_cnt_d = grant_cnt_q;
    if (|(req_valid & ~grant) && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
    if (grant_any && grant_cnt_q != 16'hFFFF) begin
      grant_cnt_d = grant_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      grant_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      grant_cnt_q <= grant_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign grant_cnt = grant_cnt_q;
`endif

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Directed bench for rom_read_arbiter: vector table plus sweep, reset, latency-3 and counter sequences.
module tb_rom_read_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [3:0]  req_valid, req_ready, rsp_valid;
  logic [27:0] req_addr;
  logic [7:0]  rsp_data, rom_data;
  logic [6:0]  rom_address;

  logic [3:0]  req_valid3, req_ready3, rsp_valid3;
  logic [27:0] req_addr3;
  logic [7:0]  rsp_data3, rom_data3, rom3_p1, rom3_p2;
  logic [6:0]  rom_address3;

`ifdef ROM_ARB_PERF_EN
  logic [15:0] stall_cnt, grant_cnt, stall_cnt3, grant_cnt3;
`endif

  rom_read_arbiter #(.NUM_REQ(4), .ADDR_W(7), .DATA_W(8), .ROM_LATENCY(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rom_address(rom_address), .rom_data(rom_data)
`ifdef ROM_ARB_PERF_EN
    , .stall_cnt(stall_cnt), .grant_cnt(grant_cnt)
`endif
  );

  rom_read_arbiter #(.NUM_REQ(4), .ADDR_W(7), .DATA_W(8), .ROM_LATENCY(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid3), .req_addr(req_addr3),
    .req_ready(req_ready3), .rsp_valid(rsp_valid3), .rsp_data(rsp_data3),
    .rom_address(rom_address3), .rom_data(rom_data3)
`ifdef ROM_ARB_PERF_EN
    , .stall_cnt(stall_cnt3), .grant_cnt(grant_cnt3)
`endif
  );

  function automatic logic [7:0] rom_val(input logic [6:0] a);
    logic [7:0] t;
    t = {1'b0, a};
    return (t * 8'd37 + 8'd11) ^ (t >> 1);
  endfunction

  // Golden ROMs: one registered stage, and a three-stage version for the latency-3 instance.
  always_ff @(posedge clk) begin
    rom_data  <= rom_val(rom_address);
    rom3_p1   <= rom_val(rom_address3);
    rom3_p2   <= rom3_p1;
    rom_data3 <= rom3_p2;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0]  v;
    logic [27:0] addr;
    logic [3:0]  rdy;
    logic [3:0]  rsp;
    logic [7:0]  dat;
    logic [6:0]  ra;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [3:0] v, input logic [27:0] a, input logic [3:0] rdy,
                     input logic [3:0] rsp, input logic [6:0] rsp_addr, input logic [6:0] ra);
    vec_t e;
    e.v = v; e.addr = a; e.rdy = rdy; e.rsp = rsp; e.dat = rom_val(rsp_addr); e.ra = ra;
    tbl.push_back(e);
  endtask

  localparam logic [27:0] A_E0  = {7'd0, 7'd0, 7'd0, 7'd5};
  localparam logic [27:0] A_ALL = {7'd13, 7'd12, 7'd11, 7'd10};

  initial begin
    rst_n = 1'b0; req_valid = '0; req_addr = '0; req_valid3 = '0; req_addr3 = '0;

    // Cycle-by-cycle vectors, response lands two cycles after its grant.
    add(4'b0001, A_E0,  4'b0001, 4'b0000, 7'd0,  7'd0);
    add(4'b0000, A_ALL, 4'b0000, 4'b0000, 7'd0,  7'd5);
    add(4'b0000, A_ALL, 4'b0000, 4'b0001, 7'd5,  7'd5);
    add(4'b1111, A_ALL, 4'b0010, 4'b0000, 7'd0,  7'd5);
    add(4'b1111, A_ALL, 4'b0100, 4'b0000, 7'd0,  7'd11);
    add(4'b1111, A_ALL, 4'b1000, 4'b0010, 7'd11, 7'd12);
    add(4'b1111, A_ALL, 4'b0001, 4'b0100, 7'd12, 7'd13);
    add(4'b1111, A_ALL, 4'b0010, 4'b1000, 7'd13, 7'd10);
    add(4'b1111, A_ALL, 4'b0100, 4'b0001, 7'd10, 7'd11);
    add(4'b1111, A_ALL, 4'b1000, 4'b0010, 7'd11, 7'd12);
    add(4'b1010, A_ALL, 4'b0010, 4'b0100, 7'd12, 7'd13);
    add(4'b1010, A_ALL, 4'b1000, 4'b1000, 7'd13, 7'd11);
    add(4'b1010, A_ALL, 4'b0010, 4'b0010, 7'd11, 7'd13);
    add(4'b1010, A_ALL, 4'b1000, 4'b1000, 7'd13, 7'd11);
    add(4'b0000, A_ALL, 4'b0000, 4'b0010, 7'd11, 7'd13);
    add(4'b0000, A_ALL, 4'b0000, 4'b1000, 7'd13, 7'd13);
    add(4'b0000, A_ALL, 4'b0000, 4'b0000, 7'd0,  7'd13);

    // Reset state, with requests present to show req_ready is held low.
    repeat (3) @(posedge clk);
    #1;
    req_valid = 4'b1111;
    #1;
    chk("reset req_ready", 32'(req_ready), 32'd0);
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset rom_address", 32'(rom_address), 32'd0);
`ifdef ROM_ARB_PERF_EN
    chk("reset grant_cnt", 32'(grant_cnt), 32'd0);
    chk("reset stall_cnt", 32'(stall_cnt), 32'd0);
`endif
    tick();
    req_valid = '0;
    rst_n = 1'b1;

    foreach (tbl[j]) begin
      req_valid = tbl[j].v;
      req_addr  = tbl[j].addr;
      #2;
      chk($sformatf("vec%0d req_ready", j), 32'(req_ready), 32'(tbl[j].rdy));
      chk($sformatf("vec%0d rsp_valid", j), 32'(rsp_valid), 32'(tbl[j].rsp));
      chk($sformatf("vec%0d rom_address", j), 32'(rom_address), 32'(tbl[j].ra));
      if (tbl[j].rsp != 4'b0000)
        chk($sformatf("vec%0d rsp_data", j), 32'(rsp_data), 32'(tbl[j].dat));
      $display("vec%0d v=%b ready=%b rsp=%b data=%0h", j, tbl[j].v, req_ready, rsp_valid, rsp_data);
      tick();
    end

    // Requester 2 sweeps the whole ROM back-to-back.
    for (int c = 0; c < 130; c++) begin
      req_valid = (c < 128) ? 4'b0100 : 4'b0000;
      req_addr  = {7'd0, 7'(c), 14'd0};
      #2;
      chk($sformatf("sweep%0d req_ready", c), 32'(req_ready), (c < 128) ? 32'h4 : 32'h0);
      chk($sformatf("sweep%0d rsp_valid", c), 32'(rsp_valid), (c >= 2) ? 32'h4 : 32'h0);
      if (c >= 2)
        chk($sformatf("sweep%0d rsp_data", c), 32'(rsp_data), 32'(rom_val(7'(c - 2))));
      tick();
    end
    req_valid = '0;
    tick();

    // Reset lands while a read is in flight; its response must never appear.
    req_valid = 4'b0001;
    req_addr  = {7'd0, 7'd0, 7'd0, 7'd7};
    tick();
    chk("inflight rom_address", 32'(rom_address), 32'd7);
    req_valid = 4'b1111;
    rst_n = 1'b0;
    #1;
    chk("midrst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst rom_address", 32'(rom_address), 32'd0);
    chk("midrst req_ready", 32'(req_ready), 32'd0);
    tick();
    chk("midrst resp cycle rsp_valid", 32'(rsp_valid), 32'd0);
    tick();
    req_valid = '0;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("postrst%0d rsp_valid", c), 32'(rsp_valid), 32'd0);
      tick();
    end
`ifdef ROM_ARB_PERF_EN
    chk("postrst grant_cnt", 32'(grant_cnt), 32'd0);
    chk("postrst stall_cnt", 32'(stall_cnt), 32'd0);
`endif

    // All four requesting for ten cycles: strict rotation starting at requester 0.
    req_valid = 4'b1111;
    req_addr  = A_ALL;
    for (int c = 0; c < 10; c++) begin
      #2;
      chk($sformatf("rr%0d req_ready", c), 32'(req_ready), 32'(4'b0001 << (c % 4)));
      tick();
    end
    req_valid = '0;
    #1;
`ifdef ROM_ARB_PERF_EN
    chk("perf grant_cnt", 32'(grant_cnt), 32'd10);
    chk("perf stall_cnt", 32'(stall_cnt), 32'd10);
`endif

    // Latency-3 instance: response visible only in the cycle after the third edge past accept.
    req_valid3 = 4'b0001;
    req_addr3  = {7'd0, 7'd0, 7'd0, 7'd9};
    #2;
    chk("lat3 req_ready", 32'(req_ready3), 32'd1);
    tick();
    req_valid3 = '0;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("lat3 edge+%0d rsp_valid", c), 32'(rsp_valid3), (c == 3) ? 32'd1 : 32'd0);
      if (c == 3)
        chk("lat3 rsp_data", 32'(rsp_data3), 32'(rom_val(7'd9)));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
